// File: rtl/tick_period_meter.sv
// Measures clk cycles between rising edges of tick_in, presents each period on a
// valid/ready output, and tracks lock against EXPECT +/- TOL.
module tick_period_meter #(
  parameter int CNT_W  = 30,
  parameter int EXPECT = 10000000,
  parameter int TOL    = 0,
  parameter int LOCK_N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             ovf,
  output logic             lost,
  output logic             locked
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // Window bounds carry one extra bit so EXPECT+TOL cannot wrap; lower bound clamps at 0.
  localparam logic [CNT_W:0] WIN_LO = (EXPECT > TOL) ? (CNT_W+1)'(EXPECT - TOL) : '0;
  localparam logic [CNT_W:0] WIN_HI = (CNT_W+1)'(EXPECT + TOL);

  localparam int              MW     = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);
  localparam logic [MW-1:0]   LOCK_C = MW'(LOCK_N);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + 1'b1;
  endfunction

  logic [0:0]       r_state;
  logic             r_tick_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic             r_valid;
  logic             r_ovf;
  logic             r_lost;
  logic             r_locked;
  logic [MW-1:0]    r_match;

  logic             w_edge;
  logic [CNT_W-1:0] w_period;
  logic             w_ovf_new;
  logic             w_in_range;
  logic [MW-1:0]    w_match_inc;

  always_comb begin
    w_edge      = tick_in & ~r_tick_d;
    w_period    = sat_inc(r_cnt);
    w_ovf_new   = (w_period == CNT_MAX);
    w_in_range  = !w_ovf_new && ({1'b0, w_period} >= WIN_LO) && ({1'b0, w_period} <= WIN_HI);
    w_match_inc = (r_match == LOCK_C) ? LOCK_C : r_match + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_tick_d <= 1'b0;
      r_cnt    <= '0;
      r_period <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_lost   <= 1'b0;
      r_locked <= 1'b0;
      r_match  <= '0;
    end else begin
      r_tick_d <= tick_in;
      if (r_valid && period_ready)
        r_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_edge) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
          end
        end
        default: begin
          if (w_edge) begin
            r_cnt <= '0;
            // A pending unconsumed result is kept; the newer one is dropped.
            if (r_valid && !period_ready) begin
              r_lost <= 1'b1;
            end else begin
              r_period <= w_period;
              r_ovf    <= w_ovf_new;
              r_valid  <= 1'b1;
            end
            if (w_in_range) begin
              r_match <= w_match_inc;
              if (w_match_inc == LOCK_C)
                r_locked <= 1'b1;
            end else begin
              r_match  <= '0;
              r_locked <= 1'b0;
            end
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
      endcase
    end
  end

  assign period_out   = r_period;
  assign period_valid = r_valid;
  assign ovf          = r_ovf;
  assign lost         = r_lost;
  assign locked       = r_locked;

endmodule
